alu_issuer: RTL and testbench
=============================

ALU_ISSUER -- requirements
Module: alu_issuer

Interface
REQ-001 Parameters SHALL be: MUL_CYCLES, 2, ALU hold cycles for OP 8/9; DIV_CYCLES, 8, ALU hold cycles for OP 10/11.
REQ-002 Ports SHALL be (name direction width meaning): CLK in 1 clock, rising edge; RESET in 1 asynchronous active-high reset.
REQ-003 req_valid in 1; req_ready out 1; req_opcode in 7; req_funct3 in 3; req_funct7 in 7 (for OP-IMM, holds imm[11:5]); req_rs1 in 64; req_rs2_imm in 64 (rs2 value or sign-extended immediate).
REQ-004 alu_X out 64; alu_Y out 64; alu_OP out 4; alu_result in 64; alu_isEqual in 1. These ports connect to the ALU combinational port pair.
REQ-005 rsp_valid out 1; rsp_ready in 1; rsp_result out 64; rsp_isEqual out 1; rsp_illegal out 1.

Function
REQ-006 The FSM SHALL have states IDLE, HOLD, RESP; transitions: IDLE->HOLD on req_valid&&req_ready for a legal request, IDLE->RESP for an illegal request, HOLD->RESP when the hold counter reaches 0, RESP->IDLE on rsp_valid&&rsp_ready.
REQ-007 req_ready SHALL be 1 only in IDLE; rsp_valid SHALL be 1 only in RESP.
REQ-008 On acceptance, the block SHALL register rs1->alu_X and rs2_imm->alu_Y, with Y[63:6] forced to 0 for OP 5/6/7, and SHALL register the decoded alu_OP.
REQ-009 Decode for opcode 0110011 (R-type) with funct7=0000000 SHALL map funct3 0..7 to OP 0,5,12,13,4,6,3,2; funct7=0100000 SHALL map funct3 000->1 and 101->7.
REQ-010 Decode for opcode 0110011 with funct7=0000001 SHALL map funct3 000->8, 001/010/011->9, 100/101->10, 110/111->11.
REQ-011 Decode for opcode 0010011 (OP-IMM) SHALL map funct3 000->0, 010->12, 011->13, 100->4, 110->3, 111->2.
REQ-012 For OP-IMM shifts, funct3 001 with funct7[6:1]=000000 SHALL map to 5; funct3 101 with funct7[6:1]=000000 SHALL map to 6; funct3 101 with funct7[6:1]=010000 SHALL map to 7.
REQ-013 Any other opcode/funct combination SHALL be illegal: rsp_illegal=1, rsp_result=0, rsp_isEqual=0, and alu_X/alu_Y/alu_OP unchanged.
REQ-014 The hold count loaded on acceptance SHALL be 0 for OP 0-7 and 12-13, MUL_CYCLES-1 for OP 8/9, and DIV_CYCLES-1 for OP 10/11; it SHALL decrement once per HOLD cycle.
REQ-015 alu_X, alu_Y and alu_OP SHALL stay stable from acceptance until the next acceptance.
REQ-016 In the last HOLD cycle, the block SHALL capture alu_result->rsp_result and alu_isEqual->rsp_isEqual, with rsp_illegal=0.
REQ-017 Latency SHALL be: for a single-cycle OP, rsp_valid rises 2 cycles after the acceptance edge; for MUL/DIV, 1+MUL_CYCLES or 1+DIV_CYCLES cycles after; for an illegal request, 1 cycle after.
REQ-018 rsp_* SHALL hold stable while rsp_valid=1 && rsp_ready=0, for unbounded backpressure.
REQ-019 In the RESP handshake cycle req_ready SHALL be 0 (no same-cycle accept); the next request is accepted at the earliest 1 cycle later.
REQ-020 Parameter values below 1 SHALL be treated as 1.

Reset
REQ-021 RESET=1 SHALL asynchronously force: state IDLE, hold counter 0, alu_X=0, alu_Y=0, alu_OP=0, rsp_result=0, rsp_isEqual=0, rsp_illegal=0, rsp_valid=0, req_ready=0 while RESET is asserted.
REQ-022 After RESET deasserts, req_ready SHALL be 1 from the first CLK edge onward.
REQ-023 RESET mid-HOLD or mid-RESP SHALL abort the transaction with no response ever produced.

Verification
REQ-024 R-type sub: rs1=10, rs2=3, funct7=0100000, funct3=000 -> alu_OP=1 and rsp_result=7 two cycles after acceptance.
REQ-025 OP-IMM srai: rs1=0x8000_0000_0000_0000, imm=0x0000_0000_0000_0403 (funct7=0100000), funct3=101 -> alu_OP=7 and alu_Y=3.
REQ-026 div with DIV_CYCLES=8: rs1=100, rs2=7, funct7=0000001, funct3=100 -> alu_OP=10 held 8 cycles; rsp_valid at +9 with rsp_result=14.
REQ-027 Illegal: opcode 0110011, funct7=0000010 -> rsp_valid at +1, rsp_illegal=1, rsp_result=0.
REQ-028 Backpressure: rsp_ready=0 for 5 cycles -> rsp_* stable and req_ready=0 throughout; acceptance resumes the cycle after rsp_ready=1.
REQ-029 RESET asserted in HOLD cycle 3 of a div -> all outputs 0 immediately; no rsp_valid after release.

Source files
------------

// File: rtl/alu_issuer.sv
// alu_issuer: decodes RV64 OP / OP-IMM requests, drives an external
// combinational ALU for a fixed hold time and returns its result.

module alu_issuer #(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [6:0]  req_opcode,
  input  logic [2:0]  req_funct3,
  input  logic [6:0]  req_funct7,
  input  logic [63:0] req_rs1,
  input  logic [63:0] req_rs2_imm,
  output logic [63:0] alu_X,
  output logic [63:0] alu_Y,
  output logic [3:0]  alu_OP,
  input  logic [63:0] alu_result,
  input  logic        alu_isEqual,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_result,
  output logic        rsp_isEqual,
  output logic        rsp_illegal
);

  // Cycle counts below 1 would make the hold counter underflow.
  localparam int MUL_EFF = (MUL_CYCLES < 1) ? 1 : MUL_CYCLES;
  localparam int DIV_EFF = (DIV_CYCLES < 1) ? 1 : DIV_CYCLES;
  localparam int MAX_EFF = (MUL_EFF > DIV_EFF) ? MUL_EFF : DIV_EFF;
  localparam int CW      = $clog2(MAX_EFF + 1);

  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_EFF - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_EFF - 1);

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_IMM = 7'b0010011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MULD = 7'b0000001;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8;
  localparam logic [3:0] OP_MULH = 4'd9;
  localparam logic [3:0] OP_DIV  = 4'd10;
  localparam logic [3:0] OP_REM  = 4'd11;
  localparam logic [3:0] OP_SLT  = 4'd12;
  localparam logic [3:0] OP_SLTU = 4'd13;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    RESP
  } state_t;

  state_t        state;
  logic [CW-1:0] hold_cnt;

  logic          is_r_base;
  logic          is_r_alt;
  logic          is_r_muld;
  logic          is_imm;
  logic          dec_legal;
  logic [3:0]    dec_op;
  logic          dec_shift;
  logic [63:0]   dec_y;
  logic [CW-1:0] dec_hold;
  logic          accept;

  assign is_r_base = (req_opcode == OPC_R) &&
                     (req_funct7 == F7_BASE);
  assign is_r_alt  = (req_opcode == OPC_R) &&
                     (req_funct7 == F7_ALT);
  assign is_r_muld = (req_opcode == OPC_R) &&
                     (req_funct7 == F7_MULD);
  assign is_imm    = (req_opcode == OPC_IMM);

  assign accept = req_valid && req_ready;

  // Decode opcode/funct fields into an ALU operation and legality.
  always_comb begin
    dec_legal = 1'b0;
    dec_op    = OP_ADD;
    unique case (1'b1)
      is_r_base: begin
        dec_legal = 1'b1;
        case (req_funct3)
          3'b000:  dec_op = OP_ADD;
          3'b001:  dec_op = OP_SLL;
          3'b010:  dec_op = OP_SLT;
          3'b011:  dec_op = OP_SLTU;
          3'b100:  dec_op = OP_XOR;
          3'b101:  dec_op = OP_SRL;
          3'b110:  dec_op = OP_OR;
          default: dec_op = OP_AND;
        endcase
      end
      is_r_alt: begin
        case (req_funct3)
          3'b000: begin
            dec_legal = 1'b1;
            dec_op    = OP_SUB;
          end
          3'b101: begin
            dec_legal = 1'b1;
            dec_op    = OP_SRA;
          end
          default: dec_legal = 1'b0;
        endcase
      end
      is_r_muld: begin
        dec_legal = 1'b1;
        case (req_funct3)
          3'b000:  dec_op = OP_MUL;
          3'b001,
          3'b010,
          3'b011:  dec_op = OP_MULH;
          3'b100,
          3'b101:  dec_op = OP_DIV;
          default: dec_op = OP_REM;
        endcase
      end
      is_imm: begin
        dec_legal = 1'b1;
        case (req_funct3)
          3'b000: dec_op = OP_ADD;
          3'b010: dec_op = OP_SLT;
          3'b011: dec_op = OP_SLTU;
          3'b100: dec_op = OP_XOR;
          3'b110: dec_op = OP_OR;
          3'b111: dec_op = OP_AND;
          3'b001: begin
            // funct7[0] is shamt[5] for 64-bit shifts
            dec_legal = (req_funct7[6:1] == 6'b000000);
            dec_op    = OP_SLL;
          end
          default: begin
            if (req_funct7[6:1] == 6'b000000) begin
              dec_op = OP_SRL;
            end else if (req_funct7[6:1] == 6'b010000) begin
              dec_op = OP_SRA;
            end else begin
              dec_legal = 1'b0;
            end
          end
        endcase
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Shift amount and hold time follow from the decoded op.
  always_comb begin
    dec_shift = (dec_op == OP_SLL) ||
                (dec_op == OP_SRL) ||
                (dec_op == OP_SRA);
    dec_y     = req_rs2_imm;
    if (dec_shift) begin
      dec_y = {58'd0, req_rs2_imm[5:0]};
    end
    dec_hold = '0;
    if ((dec_op == OP_MUL) || (dec_op == OP_MULH)) begin
      dec_hold = MUL_LOAD;
    end else if ((dec_op == OP_DIV) || (dec_op == OP_REM)) begin
      dec_hold = DIV_LOAD;
    end
  end

  // Issue FSM: accept, hold ALU operands, then present response.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      alu_X       <= '0;
      alu_Y       <= '0;
      alu_OP      <= '0;
      rsp_result  <= '0;
      rsp_isEqual <= 1'b0;
      rsp_illegal <= 1'b0;
      rsp_valid   <= 1'b0;
      req_ready   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            req_ready <= 1'b0;
            if (dec_legal) begin
              alu_X    <= req_rs1;
              alu_Y    <= dec_y;
              alu_OP   <= dec_op;
              hold_cnt <= dec_hold;
              state    <= HOLD;
            end else begin
              // Operand registers keep the previous request.
              rsp_result  <= '0;
              rsp_isEqual <= 1'b0;
              rsp_illegal <= 1'b1;
              rsp_valid   <= 1'b1;
              state       <= RESP;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        HOLD: begin
          if (hold_cnt == '0) begin
            rsp_result  <= alu_result;
            rsp_isEqual <= alu_isEqual;
            rsp_illegal <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issuer.sv
// tb_alu_issuer: directed and random requests against a cycle-level
// reference model; the bench also plays the role of the ALU.

module tb_alu_issuer;

  localparam int MULC = 2;
  localparam int DIVC = 8;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_IMM = 7'b0010011;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [6:0]  req_opcode = '0;
  logic [2:0]  req_funct3 = '0;
  logic [6:0]  req_funct7 = '0;
  logic [63:0] req_rs1 = '0;
  logic [63:0] req_rs2_imm = '0;
  logic [63:0] alu_X;
  logic [63:0] alu_Y;
  logic [3:0]  alu_OP;
  logic [63:0] alu_result;
  logic        alu_isEqual;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [63:0] rsp_result;
  logic        rsp_isEqual;
  logic        rsp_illegal;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  alu_issuer #(
    .MUL_CYCLES(MULC),
    .DIV_CYCLES(DIVC)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_funct3 (req_funct3),
    .req_funct7 (req_funct7),
    .req_rs1    (req_rs1),
    .req_rs2_imm(req_rs2_imm),
    .alu_X      (alu_X),
    .alu_Y      (alu_Y),
    .alu_OP     (alu_OP),
    .alu_result (alu_result),
    .alu_isEqual(alu_isEqual),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_isEqual(rsp_isEqual),
    .rsp_illegal(rsp_illegal)
  );

  function automatic logic [63:0] alu_fn(
    input logic [3:0]  op,
    input logic [63:0] a,
    input logic [63:0] b
  );
    logic signed [127:0] p;
    p = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << b[5:0];
      4'd6:    return a >> b[5:0];
      4'd7:    return $signed(a) >>> b[5:0];
      4'd8:    return a * b;
      4'd9:    return p[127:64];
      4'd10:   return (b == 0) ? '1 : a / b;
      4'd11:   return (b == 0) ? a : a % b;
      4'd12:   return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      4'd13:   return (a < b) ? 64'd1 : 64'd0;
      default: return 64'd0;
    endcase
  endfunction

  // The external ALU, combinational on the issued operands.
  always_comb begin
    alu_result  = alu_fn(alu_OP, alu_X, alu_Y);
    alu_isEqual = (alu_X == alu_Y);
  end

  // Instruction table: which fields are legal and what op they name.
  task automatic ref_decode(
    input  logic [6:0] opc,
    input  logic [2:0] f3,
    input  logic [6:0] f7,
    output bit         legal,
    output logic [3:0] op
  );
    logic [3:0] r_tab [8];
    logic [3:0] m_tab [8];
    r_tab = '{4'd0, 4'd5, 4'd12, 4'd13, 4'd4, 4'd6, 4'd3, 4'd2};
    m_tab = '{4'd8, 4'd9, 4'd9, 4'd9, 4'd10, 4'd10, 4'd11, 4'd11};
    legal = 0;
    op    = 4'd0;
    if (opc == OPC_R) begin
      if (f7 == 7'b0000000) begin
        legal = 1; op = r_tab[f3];
      end else if (f7 == 7'b0000001) begin
        legal = 1; op = m_tab[f3];
      end else if (f7 == 7'b0100000 && f3 == 3'd0) begin
        legal = 1; op = 4'd1;
      end else if (f7 == 7'b0100000 && f3 == 3'd5) begin
        legal = 1; op = 4'd7;
      end
    end else if (opc == OPC_IMM) begin
      if (f3 != 3'd1 && f3 != 3'd5) begin
        legal = 1; op = r_tab[f3];
      end else if (f7[6:1] == 6'b000000) begin
        legal = 1; op = (f3 == 3'd1) ? 4'd5 : 4'd6;
      end else if (f3 == 3'd5 && f7[6:1] == 6'b010000) begin
        legal = 1; op = 4'd7;
      end
    end
  endtask

  function automatic int ref_lat(input logic [3:0] op);
    if (op == 4'd8 || op == 4'd9) return 1 + MULC;
    if (op == 4'd10 || op == 4'd11) return 1 + DIVC;
    return 2;
  endfunction

  // Reference model state (what each output must be this cycle).
  bit          m_ready, m_busy, m_rv, m_ill, m_eq, m_acc, p_eq, d_lg;
  logic [63:0] m_x, m_y, m_res, p_res;
  logic [3:0]  m_op, d_op;
  int          m_wait;

  // Reference model: advances once per clock, cleared by reset.
  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      m_ready = 0; m_busy = 0; m_rv = 0; m_ill = 0; m_eq = 0;
      m_acc = 0; m_x = 0; m_y = 0; m_op = 0; m_res = 0;
      m_wait = 0;
    end else begin
      m_acc = 0;
      if (m_rv) begin
        if (rsp_ready) begin
          m_rv = 0; m_ready = 1;
        end
      end else if (m_busy) begin
        m_wait--;
        if (m_wait == 0) begin
          m_busy = 0; m_rv = 1; m_res = p_res;
          m_eq = p_eq; m_ill = 0;
        end
      end else if (req_valid && m_ready) begin
        m_acc = 1; m_ready = 0;
        ref_decode(req_opcode, req_funct3, req_funct7, d_lg, d_op);
        if (d_lg) begin
          m_x  = req_rs1;
          m_y  = (d_op >= 4'd5 && d_op <= 4'd7) ?
                 {58'd0, req_rs2_imm[5:0]} : req_rs2_imm;
          m_op = d_op;
          p_res  = alu_fn(m_op, m_x, m_y);
          p_eq   = (m_x == m_y);
          m_wait = ref_lat(d_op) - 1;
          m_busy = 1;
        end else begin
          m_rv = 1; m_res = 0; m_eq = 0; m_ill = 1;
        end
      end else begin
        m_ready = 1;
      end
    end
  end

  task automatic chk(
    input string       nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Compare every output against the model on each falling edge.
  always @(negedge CLK) begin
    if (RESET) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_alu_X", alu_X, 0);
      chk("rst_alu_Y", alu_Y, 0);
      chk("rst_alu_OP", alu_OP, 0);
      chk("rst_rsp_result", rsp_result, 0);
      chk("rst_rsp_isEqual", rsp_isEqual, 0);
      chk("rst_rsp_illegal", rsp_illegal, 0);
    end else begin
      chk("req_ready", req_ready, m_ready);
      chk("rsp_valid", rsp_valid, m_rv);
      chk("alu_X", alu_X, m_x);
      chk("alu_Y", alu_Y, m_y);
      chk("alu_OP", alu_OP, m_op);
      if (m_rv) begin
        chk("rsp_result", rsp_result, m_res);
        chk("rsp_isEqual", rsp_isEqual, m_eq);
        chk("rsp_illegal", rsp_illegal, m_ill);
      end
    end
  end

  // Present one request when the model is idle; returns one cycle
  // after the handshake cycle with req_valid dropped.
  task automatic issue(
    input logic [6:0]  opc,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [63:0] a,
    input logic [63:0] b
  );
    for (int i = 0; i < 40 && !m_ready; i++) @(negedge CLK);
    if (!m_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL issue_timeout: ready never seen");
    end
    req_opcode  = opc;
    req_funct3  = f3;
    req_funct7  = f7;
    req_rs1     = a;
    req_rs2_imm = b;
    req_valid   = 1;
    @(negedge CLK);
    req_valid = 0;
  endtask

  initial begin
    #1 RESET = 1;
    repeat (3) @(negedge CLK);
    RESET = 0;
    @(negedge CLK);
    chk("ready_after_reset", req_ready, 1);

    // sub 10-3: op 1, result two cycles after the handshake cycle
    issue(OPC_R, 3'd0, 7'b0100000, 64'd10, 64'd3);
    chk("sub_op", alu_OP, 4'd1);
    chk("sub_early", rsp_valid, 0);
    @(negedge CLK);
    chk("sub_valid", rsp_valid, 1);
    chk("sub_result", rsp_result, 64'd7);
    @(negedge CLK);

    // srai: shift amount only from imm[5:0]
    issue(OPC_IMM, 3'd5, 7'b0100000,
          64'h8000_0000_0000_0000, 64'h0000_0000_0000_0403);
    chk("srai_op", alu_OP, 4'd7);
    chk("srai_y", alu_Y, 64'd3);
    @(negedge CLK);
    chk("srai_result", rsp_result, 64'hF000_0000_0000_0000);
    @(negedge CLK);

    // mul 6*7: valid at +3
    issue(OPC_R, 3'd0, 7'b0000001, 64'd6, 64'd7);
    chk("mul_wait1", rsp_valid, 0);
    @(negedge CLK);
    chk("mul_wait2", rsp_valid, 0);
    @(negedge CLK);
    chk("mul_valid", rsp_valid, 1);
    chk("mul_result", rsp_result, 64'd42);
    @(negedge CLK);

    // div 100/7 with backpressure on the response
    issue(OPC_R, 3'd4, 7'b0000001, 64'd100, 64'd7);
    rsp_ready = 0;
    for (int i = 1; i <= 8; i++) begin
      chk("div_op_held", alu_OP, 4'd10);
      chk("div_hold", rsp_valid, 0);
      @(negedge CLK);
    end
    chk("div_valid", rsp_valid, 1);
    chk("div_result", rsp_result, 64'd14);
    req_opcode  = OPC_R;
    req_funct3  = 3'd0;
    req_funct7  = 7'b0100000;
    req_rs1     = 64'd50;
    req_rs2_imm = 64'd8;
    req_valid   = 1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", rsp_valid, 1);
      chk("bp_result", rsp_result, 64'd14);
      chk("bp_ready", req_ready, 0);
      @(negedge CLK);
    end
    rsp_ready = 1;
    @(negedge CLK);
    chk("bp_resume_ready", req_ready, 1);
    chk("bp_resume_valid", rsp_valid, 0);
    @(negedge CLK);
    req_valid = 0;
    chk("bp_next_op", alu_OP, 4'd1);
    @(negedge CLK);
    chk("bp_next_result", rsp_result, 64'd42);
    @(negedge CLK);

    // illegal funct7: immediate response, operands untouched
    issue(OPC_R, 3'd0, 7'b0000010, 64'd5, 64'd6);
    chk("ill_valid", rsp_valid, 1);
    chk("ill_flag", rsp_illegal, 1);
    chk("ill_result", rsp_result, 0);
    chk("ill_op_kept", alu_OP, 4'd1);
    chk("ill_x_kept", alu_X, 64'd50);
    @(negedge CLK);

    // reset in the third hold cycle of a divide
    issue(OPC_R, 3'd4, 7'b0000001, 64'd100, 64'd7);
    repeat (2) @(negedge CLK);
    #2 RESET = 1;
    #1;
    chk("rst_mid_valid", rsp_valid, 0);
    chk("rst_mid_op", alu_OP, 0);
    chk("rst_mid_x", alu_X, 0);
    chk("rst_mid_ready", req_ready, 0);
    repeat (2) @(negedge CLK);
    RESET = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge CLK);
      chk("rst_no_rsp", rsp_valid, 0);
    end

    // randomized traffic, checked by the model every cycle
    for (int c = 0; c < 4000; c++) begin
      @(negedge CLK);
      rsp_ready = ($urandom_range(0, 3) != 0);
      if (req_valid && m_acc) req_valid = 0;
      if (!req_valid && $urandom_range(0, 2) == 0) begin
        int k;
        k = $urandom_range(0, 9);
        req_opcode = (k < 5) ? OPC_R :
                     (k < 9) ? OPC_IMM : 7'($urandom);
        req_funct3 = 3'($urandom);
        case ($urandom_range(0, 4))
          0: req_funct7 = 7'b0000000;
          1: req_funct7 = 7'b0100000;
          2: req_funct7 = 7'b0000001;
          3: req_funct7 = 7'b0100001;
          default: req_funct7 = 7'($urandom);
        endcase
        req_rs1 = {$urandom, $urandom};
        case ($urandom_range(0, 3))
          0: req_rs2_imm = req_rs1;
          1: req_rs2_imm = 64'($urandom_range(0, 70));
          default: req_rs2_imm = {$urandom, $urandom};
        endcase
        req_valid = 1;
      end
    end

    req_valid = 0;
    rsp_ready = 1;
    repeat (20) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
